// File: rtl/multi_ch_rr_packer_pkg.sv
// -----------------------------------------------------------------------------
// multi_ch_pkg
// Shared definitions for the multi-channel round-robin packer:
//   - uplink header constants (sync byte, channel-id and sequence widths)
//   - output-stage state encoding
//   - pack_uplink_hdr(): builds the 32-bit header {sync, ch id, seq} that sits
//     above the data field of every uplink word.
// The per-channel entry layout {seq, data} depends on DATA_W, so the top
// declares it as a packed struct built from seq_t.
// -----------------------------------------------------------------------------
package multi_ch_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'h5A;
  localparam int         SEQ_W     = 16;
  localparam int         CH_ID_W   = 8;
  localparam int         HDR_W     = 8 + CH_ID_W + SEQ_W;

  typedef logic [SEQ_W-1:0]   seq_t;
  typedef logic [CH_ID_W-1:0] ch_id_t;

  typedef enum logic {
    ST_EMPTY  = 1'b0,
    ST_LOADED = 1'b1
  } out_state_e;

  // Header occupies the top HDR_W bits of the uplink word; data follows.
  function automatic logic [HDR_W-1:0] pack_uplink_hdr(input ch_id_t ch_id,
                                                       input seq_t   seq);
    return {SYNC_BYTE, ch_id, seq};
  endfunction

endpackage

// File: rtl/multi_ch_rr_packer_sc_fifo.sv
// -----------------------------------------------------------------------------
// sc_fifo
// Single-clock first-word-fall-through FIFO.
//   ch1_wrclk  clock (rising edge)
//   rst_n      asynchronous active-low reset (pointers only)
//   wr_en/din  write strobe and data; ignored while full
//   rd_en      pop the head entry; ignored while empty
//   dout       head entry, valid whenever empty=0
//   full/empty status derived from the registered pointers, so a write into
//              an empty FIFO is not visible until the next cycle and a write
//              into a full FIFO is dropped even if a pop happens alongside.
// Params: WIDTH (entry width), DEPTH (power of 2, >= 2).
// -----------------------------------------------------------------------------
module sc_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 16
) (
  input  logic             ch1_wrclk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // Extra MSB distinguishes full from empty when the address bits match.
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             push, pop;

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign push  = wr_en && !full;
  assign pop   = rd_en && !empty;
  assign dout  = mem[rd_ptr_q[AW-1:0]];

  always_ff @(posedge ch1_wrclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // NOTE: the storage array has no reset; contents are only ever read behind
  // valid pointers, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge ch1_wrclk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/multi_ch_rr_packer.sv
// -----------------------------------------------------------------------------
// multi_ch_rr_packer
// N-channel ingest buffer: one sc_fifo per channel, drained round-robin into a
// single registered uplink word {8'h5A, ch id, seq, data} with valid/ready.
// Ports:
//   ch1_wrclk   single clock for all logic
//   rst_n       asynchronous active-low reset
//   ch_wrreq    per-channel write strobe
//   ch_data     channel k data in bits [k*DATA_W +: DATA_W]
//   ch_full     FIFO k full
//   ch_ovf      sticky: a write to channel k was dropped
//   up_ready    uplink sink accepts the current word
//   data_valid  up_data holds a word
//   up_data     {SYNC_BYTE, ch id, seq, data}
//   drop_cnt    (only with MULTI_CH_RR_PACKER_DROP_CNT_EN) per-channel
//               saturating dropped-write counters, 16 bits each
// -----------------------------------------------------------------------------
module multi_ch_rr_packer
  import multi_ch_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 16,
  localparam int OUT_W  = DATA_W + 32
) (
  input  logic                     ch1_wrclk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        ch_wrreq,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [NUM_CH-1:0]        ch_full,
  output logic [NUM_CH-1:0]        ch_ovf,
  input  logic                     up_ready,
  output logic                     data_valid,
  output logic [OUT_W-1:0]         up_data
`ifdef MULTI_CH_RR_PACKER_DROP_CNT_EN
  ,
  output logic [NUM_CH*16-1:0]     drop_cnt
`endif
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef struct packed {
    seq_t              seq;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            fifo_din  [NUM_CH];
  entry_t            fifo_dout [NUM_CH];
  logic [NUM_CH-1:0] fifo_empty;
  logic [NUM_CH-1:0] fifo_rd;

  // ---------------------------------------------------------------- channels
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    seq_t seq_q;

    assign fifo_din[k] = '{seq: seq_q, data: ch_data[k*DATA_W +: DATA_W]};

    sc_fifo #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (DEPTH)
    ) u_fifo (
      .ch1_wrclk (ch1_wrclk),
      .rst_n     (rst_n),
      .wr_en     (ch_wrreq[k]),
      .din       (fifo_din[k]),
      .rd_en     (fifo_rd[k]),
      .dout      (fifo_dout[k]),
      .full      (ch_full[k]),
      .empty     (fifo_empty[k])
    );

    // Counts every request, dropped or not, so the sink can see gaps.
    always_ff @(posedge ch1_wrclk or negedge rst_n) begin
      if (!rst_n)           seq_q <= '0;
      else if (ch_wrreq[k]) seq_q <= seq_q + SEQ_W'(1);
    end

`ifdef MULTI_CH_RR_PACKER_DROP_CNT_EN
    logic [15:0] drop_q;

    always_ff @(posedge ch1_wrclk or negedge rst_n) begin
      if (!rst_n) begin
        drop_q <= '0;
      end else if (ch_wrreq[k] && ch_full[k] && (drop_q != 16'hFFFF)) begin
        drop_q <= drop_q + 16'd1;
      end
    end

    assign drop_cnt[k*16 +: 16] = drop_q;
    assign ch_ovf[k]            = (drop_q != '0);
`else
    logic ovf_q;

    always_ff @(posedge ch1_wrclk or negedge rst_n) begin
      if (!rst_n)                         ovf_q <= 1'b0;
      else if (ch_wrreq[k] && ch_full[k]) ovf_q <= 1'b1;
    end

    assign ch_ovf[k] = ovf_q;
`endif
  end

  // ---------------------------------------------------------------- arbiter
  logic [IDX_W-1:0] start_q;     // next channel to try first
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] next_start;
  logic             any_pend;
  logic             do_pop;
  entry_t           sel_entry;
  out_state_e       state_q;
  logic             data_valid_q;
  logic [OUT_W-1:0] up_data_q;

  function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] start,
                                               input int               offs);
    int c;
    c = int'(start) + offs;
    if (c >= NUM_CH) c -= NUM_CH;
    return IDX_W'(c);
  endfunction

  always_comb begin
    // NOTE: every output of this block gets a default before the loop, so no
    // path leaves a value unassigned and no latch is inferred.
    grant_idx = '0;
    any_pend  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!any_pend && !fifo_empty[rr_idx(start_q, i)]) begin
        any_pend  = 1'b1;
        grant_idx = rr_idx(start_q, i);
      end
    end
  end

  // The output register can take a new word when empty or when the current
  // word is leaving this cycle, giving one word per cycle under up_ready=1.
  assign do_pop     = any_pend && ((state_q == ST_EMPTY) || up_ready);
  assign sel_entry  = fifo_dout[grant_idx];
  assign next_start = (int'(grant_idx) == NUM_CH - 1) ? '0
                                                      : grant_idx + IDX_W'(1);

  always_comb begin
    fifo_rd = '0;
    if (do_pop) fifo_rd[grant_idx] = 1'b1;
  end

  // ------------------------------------------------------------ output stage
  always_ff @(posedge ch1_wrclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_EMPTY;
      data_valid_q <= 1'b0;
      up_data_q    <= '0;
      start_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every decision in this
      // block sees the pre-edge register values regardless of statement order.
      case (state_q)
        ST_EMPTY: begin
          if (do_pop) begin
            state_q      <= ST_LOADED;
            data_valid_q <= 1'b1;
            up_data_q    <= {pack_uplink_hdr(ch_id_t'(grant_idx), sel_entry.seq),
                             sel_entry.data};
            start_q      <= next_start;
          end
        end
        ST_LOADED: begin
          if (do_pop) begin
            up_data_q <= {pack_uplink_hdr(ch_id_t'(grant_idx), sel_entry.seq),
                          sel_entry.data};
            start_q   <= next_start;
          end else if (up_ready) begin
            state_q      <= ST_EMPTY;
            data_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= ST_EMPTY;
          data_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign data_valid = data_valid_q;
  assign up_data    = up_data_q;

endmodule

// File: tb/tb_multi_ch_rr_packer.sv
// -----------------------------------------------------------------------------
// tb_multi_ch_rr_packer
// Reference model: per-channel queues with a round-robin drain, evaluated once
// per clock edge; loaded words go into a scoreboard queue that a negedge
// monitor pops whenever the DUT presents a new uplink word.
// -----------------------------------------------------------------------------
module tb_multi_ch_rr_packer;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int OUT_W  = DATA_W + 32;

  logic                     ch1_wrclk = 1'b0;
  logic                     rst_n     = 1'b1;
  logic [NUM_CH-1:0]        ch_wrreq  = '0;
  logic [NUM_CH*DATA_W-1:0] ch_data   = '0;
  logic                     up_ready  = 1'b0;
  logic [NUM_CH-1:0]        ch_full;
  logic [NUM_CH-1:0]        ch_ovf;
  logic                     data_valid;
  logic [OUT_W-1:0]         up_data;
`ifdef MULTI_CH_RR_PACKER_DROP_CNT_EN
  logic [NUM_CH*16-1:0]     drop_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  multi_ch_rr_packer #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .ch1_wrclk  (ch1_wrclk),
    .rst_n      (rst_n),
    .ch_wrreq   (ch_wrreq),
    .ch_data    (ch_data),
    .ch_full    (ch_full),
    .ch_ovf     (ch_ovf),
    .up_ready   (up_ready),
    .data_valid (data_valid),
    .up_data    (up_data)
`ifdef MULTI_CH_RR_PACKER_DROP_CNT_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  always #5 ch1_wrclk = ~ch1_wrclk;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge ch1_wrclk);
    #1;
  endtask

  // ------------------------------------------------------------------ model
  typedef struct packed {
    logic [15:0] seq;
    logic [31:0] data;
  } ment_t;

  ment_t       mq [NUM_CH][$];
  logic [15:0] m_seq  [NUM_CH];
  int unsigned m_drop [NUM_CH];
  logic [NUM_CH-1:0] m_ovf = '0;
  int          m_ptr   = 0;
  bit          m_valid = 1'b0;
  logic [63:0] exp_q [$];

  task automatic model_reset();
    for (int k = 0; k < NUM_CH; k++) begin
      mq[k].delete();
      m_seq[k]  = '0;
      m_drop[k] = 0;
    end
    m_ovf   = '0;
    m_ptr   = 0;
    m_valid = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step();
    int    sz [NUM_CH];
    bit    found;
    int    g;
    ment_t e;
    for (int k = 0; k < NUM_CH; k++) sz[k] = mq[k].size();
    // Output register: refill if empty or the current word leaves now.
    if (!m_valid || up_ready) begin
      found = 1'b0;
      g     = 0;
      for (int i = 0; i < NUM_CH; i++) begin
        int c = (m_ptr + i) % NUM_CH;
        if (!found && mq[c].size() > 0) begin
          found = 1'b1;
          g     = c;
        end
      end
      if (found) begin
        e = mq[g].pop_front();
        exp_q.push_back({8'h5A, 8'(g), e.seq, e.data});
        m_valid = 1'b1;
        m_ptr   = (g + 1) % NUM_CH;
      end else begin
        m_valid = 1'b0;
      end
    end
    // Writes see occupancy from the start of the cycle; new entries are
    // appended after the pop, so they cannot leave in the same cycle.
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_wrreq[k]) begin
        if (sz[k] < DEPTH) begin
          mq[k].push_back('{seq: m_seq[k], data: ch_data[k*DATA_W +: DATA_W]});
        end else begin
          m_ovf[k] = 1'b1;
          if (m_drop[k] < 65535) m_drop[k]++;
        end
        m_seq[k] = m_seq[k] + 16'd1;
      end
    end
  endtask

  function automatic logic [NUM_CH-1:0] m_full_vec();
    logic [NUM_CH-1:0] v;
    for (int k = 0; k < NUM_CH; k++) v[k] = (mq[k].size() >= DEPTH);
    return v;
  endfunction

  always @(posedge ch1_wrclk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // ---------------------------------------------------------------- monitor
  logic [63:0] cur_exp = '0;
  bit          prev_v  = 1'b0;
  bit          prev_r  = 1'b0;
  logic [15:0] ch1_seq_last;
  logic [15:0] ch1_seq_prev;

  always @(negedge ch1_wrclk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
      prev_r = 1'b0;
      check("valid_in_reset", 64'(data_valid), 64'd0);
    end else begin
      check("data_valid", 64'(data_valid), 64'(m_valid));
      if (data_valid && (!prev_v || prev_r)) begin
        check("word_pending", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          cur_exp = exp_q.pop_front();
          check("up_data_new", up_data, cur_exp);
          if (up_data[55:48] == 8'd1) begin
            ch1_seq_prev = ch1_seq_last;
            ch1_seq_last = up_data[47:32];
          end
        end
      end else if (data_valid) begin
        check("up_data_hold", up_data, cur_exp);
      end
      check("ch_full", 64'(ch_full), 64'(m_full_vec()));
      check("ch_ovf", 64'(ch_ovf), 64'(m_ovf));
`ifdef MULTI_CH_RR_PACKER_DROP_CNT_EN
      for (int k = 0; k < NUM_CH; k++)
        check("drop_cnt", 64'(drop_cnt[k*16 +: 16]), 64'(m_drop[k]));
`endif
      prev_v = data_valid;
      prev_r = up_ready;
    end
  end

  // --------------------------------------------------------------- stimulus
  task automatic apply_reset();
    ch_wrreq = '0;
    up_ready = 1'b0;
    rst_n    = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #1 rst_n = 1'b0;
    tick();
    tick();
    check("rst_valid", 64'(data_valid), 64'd0);
    check("rst_up_data", up_data, 64'd0);
    check("rst_full", 64'(ch_full), 64'd0);
    check("rst_ovf", 64'(ch_ovf), 64'd0);
    rst_n = 1'b1;
    tick();

    // 1: single write on ch2, latency two cycles
    up_ready = 1'b1;
    ch_wrreq = 4'b0100;
    ch_data[2*DATA_W +: DATA_W] = 32'h0000_00AB;
    tick();
    ch_wrreq = '0;
    check("t1_valid_n1", 64'(data_valid), 64'd0);
    tick();
    check("t1_valid_n2", 64'(data_valid), 64'd1);
    check("t1_up_data", up_data, 64'h5A02_0000_0000_00AB);
    tick();
    check("t1_valid_n3", 64'(data_valid), 64'd0);

    // 2: all channels at once, twice -> order 0,1,2,3 both times
    apply_reset();
    up_ready = 1'b1;
    repeat (2) begin
      ch_wrreq = '1;
      for (int k = 0; k < NUM_CH; k++) ch_data[k*DATA_W +: DATA_W] = 32'h11 * (k + 1);
      tick();
      ch_wrreq = '0;
      tick();
      for (int k = 0; k < NUM_CH; k++) begin
        check("t2_valid", 64'(data_valid), 64'd1);
        check("t2_ch_id", 64'(up_data[55:48]), 64'(k));
        check("t2_data", 64'(up_data[31:0]), 64'(32'h11 * (k + 1)));
        tick();
      end
      check("t2_idle", 64'(data_valid), 64'd0);
    end

    // 3: backpressure holds the word stable, then exactly one transfer
    up_ready = 1'b0;
    ch_wrreq = 4'b0010;
    ch_data[1*DATA_W +: DATA_W] = 32'h0000_5555;
    tick();
    ch_wrreq = '0;
    tick();
    repeat (5) begin
      check("t3_valid_held", 64'(data_valid), 64'd1);
      check("t3_data_held", up_data, 64'h5A01_0002_0000_5555);
      tick();
    end
    up_ready = 1'b1;
    tick();
    check("t3_after_xfer", 64'(data_valid), 64'd0);

    // 4: overflow on ch0 while the output register is occupied by ch3
    apply_reset();
    ch_wrreq = 4'b1000;
    ch_data[3*DATA_W +: DATA_W] = 32'h0000_00C3;
    tick();
    ch_wrreq = '0;
    tick();
    check("t4_out_loaded", 64'(data_valid), 64'd1);
    for (int i = 0; i < 17; i++) begin
      ch_wrreq = 4'b0001;
      ch_data[0 +: DATA_W] = 32'hD000 + i;
      tick();
      if (i == 14) check("t4_not_full_15", 64'(ch_full[0]), 64'd0);
      if (i == 15) check("t4_full_16", 64'(ch_full[0]), 64'd1);
    end
    ch_wrreq = '0;
    check("t4_ovf", 64'(ch_ovf[0]), 64'd1);
`ifdef MULTI_CH_RR_PACKER_DROP_CNT_EN
    check("t4_drop_cnt", 64'(drop_cnt[15:0]), 64'd1);
`endif
    up_ready = 1'b1;
    repeat (20) tick();
    check("t4_drained", 64'(data_valid), 64'd0);
    ch_wrreq = 4'b0001;
    ch_data[0 +: DATA_W] = 32'h0000_00E0;
    tick();
    ch_wrreq = '0;
    tick();
    check("t4_valid_after", 64'(data_valid), 64'd1);
    check("t4_seq_gap", 64'(up_data[47:32]), 64'h0011);

    // 5: reset while words are buffered and presented
    up_ready = 1'b0;
    ch_wrreq = '1;
    repeat (3) begin
      for (int k = 0; k < NUM_CH; k++) ch_data[k*DATA_W +: DATA_W] = $urandom();
      tick();
    end
    ch_wrreq = '0;
    tick();
    check("t5_valid_before", 64'(data_valid), 64'd1);
    @(posedge ch1_wrclk);
    #3;
    rst_n = 1'b0;
    #1;
    check("t5_valid_async", 64'(data_valid), 64'd0);
    check("t5_full_async", 64'(ch_full), 64'd0);
    tick();
    tick();
    rst_n    = 1'b1;
    up_ready = 1'b1;
    repeat (5) begin
      tick();
      check("t5_idle", 64'(data_valid), 64'd0);
    end
    ch_wrreq = 4'b0100;
    ch_data[2*DATA_W +: DATA_W] = 32'h0000_0077;
    tick();
    ch_wrreq = '0;
    tick();
    check("t5_valid_new", 64'(data_valid), 64'd1);
    check("t5_seq_restart", up_data, 64'h5A02_0000_0000_0077);

    // Randomized traffic with alternating light and heavy backpressure
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (((cyc / 100) % 2) == 0) up_ready = ($urandom_range(0, 99) < 90);
      else                        up_ready = ($urandom_range(0, 99) < 20);
      for (int k = 0; k < NUM_CH; k++) begin
        ch_wrreq[k] = ($urandom_range(0, 99) < 30);
        ch_data[k*DATA_W +: DATA_W] = $urandom();
      end
      tick();
    end
    ch_wrreq = '0;
    up_ready = 1'b1;
    repeat (80) tick();
    check("rand_drained", 64'(data_valid), 64'd0);
    check("rand_scoreboard_empty", 64'(exp_q.size()), 64'd0);

    // 6: sequence counter wrap on ch1
    apply_reset();
    up_ready = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      ch_wrreq = 4'b0010;
      ch_data[1*DATA_W +: DATA_W] = i;
      tick();
    end
    ch_wrreq = '0;
    repeat (5) tick();
    check("t6_seq_ffff", 64'(ch1_seq_prev), 64'hFFFF);
    check("t6_seq_0000", 64'(ch1_seq_last), 64'h0000);
    check("t6_no_ovf", 64'(ch_ovf), 64'd0);
    check("t6_idle", 64'(data_valid), 64'd0);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before end of stimulus");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/multi_ch_rr_packer.md
Name: multi_ch_rr_packer

Overview:
Parametrised N-channel ingest buffer that replaces the fixed 4-channel FIFO test block. All channels share one clock domain. Each channel has its own synchronous FIFO. A round-robin arbiter drains the FIFOs into a single tagged uplink word carrying a sync byte, channel ID, per-channel sequence number and data. The uplink uses a valid/ready handshake toward the upstream packetiser, so downstream backpressure is supported.

Parameters:
NUM_CH, 4, number of input channels (1..256)
DATA_W, 32, per-channel data width
DEPTH, 16, per-channel FIFO depth in entries (power of 2, >=2)
OUT_W (localparam), DATA_W+32, uplink word width

Ports:
ch1_wrclk  in  1  single clock for all logic; rising edge
rst_n  in  1  reset, asynchronous, active-low
ch_wrreq  in  NUM_CH  per-channel write strobe, 1-cycle pulses or level
ch_data  in  NUM_CH*DATA_W  channel k data in bits [k*DATA_W +: DATA_W]
ch_full  out  NUM_CH  FIFO k full
ch_ovf  out  NUM_CH  sticky flag: a write to channel k was dropped
up_ready  in  1  uplink sink accepts the word
data_valid  out  1  up_data is valid
up_data  out  OUT_W  {8'h5A, 8-bit ch id, 16-bit seq, DATA_W data}

Behaviour:
- Clock and reset: ch1_wrclk clocks everything; reset rst_n is asynchronous, active-low.
- Reset values: all FIFOs empty; data_valid=0; up_data=0; ch_full=0; ch_ovf=0; seq counters=0; round-robin pointer=0 (channel 0 highest priority first).
- Sequence counter:
  - Each channel has a 16-bit counter that increments on every ch_wrreq, including dropped writes, so the sink can detect gaps.
  - The entry stores {seq, data} captured in the same cycle. The counter wraps 0xFFFF->0x0000.
- Write:
  - Accepted when ch_wrreq[k] && !ch_full[k], sampled at the start of the cycle.
  - A write to a full FIFO is dropped and ch_ovf[k] is set. ch_ovf is cleared only by reset.
  - No write-through: a write and a pop on the same full FIFO in one cycle still drops the write.
- Output stage: 2-state machine.
  - EMPTY: data_valid=0. If any FIFO is non-empty, pop the granted channel and load the output register -> LOADED.
  - LOADED: data_valid=1 and up_data is held stable while up_ready=0.
    - On up_ready=1 (transfer) with another channel pending: pop and reload in the same cycle, stay LOADED. This gives full throughput of one word/cycle.
    - On transfer with none pending: -> EMPTY.
- Arbiter:
  - Search starts at last_grant+1 modulo NUM_CH and takes the first non-empty FIFO.
  - The pointer updates only on a pop.
  - Channel ID is zero-extended to 8 bits.
- Latency: write in cycle N -> FIFO non-empty at N+1 -> data_valid=1 at N+2 (output empty, no competing channels).
- Empty-FIFO write: the entry is not poppable in the same cycle.
- Reset mid-operation: data_valid drops immediately (asynchronously); all buffered entries are discarded.

Optional Feature:
- Macro: MULTI_CH_RR_PACKER_DROP_CNT_EN.
- Defined:
  - Adds output port drop_cnt, NUM_CH*16 bits: per-channel saturating counters of dropped writes (stick at 0xFFFF), reset to 0.
  - ch_ovf[k] is then equivalent to drop_cnt[k]!=0.
- Undefined: port and counters are absent; only the sticky ch_ovf bits exist.

Decomposition:
- Package multi_ch_pkg contains:
  - SYNC_BYTE=8'h5A
  - SEQ_W=16
  - CH_ID_W=8
  - a parametrised entry layout (seq + data) typedef
  - a function packing the uplink word
- Sub-module sc_fifo: single-clock FIFO with params WIDTH and DEPTH and ports wr_en, din, rd_en, dout (first-word-fall-through), full, empty. Instantiated NUM_CH times via generate.
- Arbiter and output stage stay in the top module.

Test Plan:
1. Defaults, up_ready=1, single ch_wrreq[2] with data 0x000000AB at cycle N -> data_valid=1 at N+2 only; up_data=64'h5A02_0000_0000_00AB.
2. All 4 channels write in the same cycle with data 0x11,0x22,0x33,0x44, up_ready=1 -> four consecutive valid words, ch 0,1,2,3. Repeating the burst gives order 0,1,2,3 again, since the pointer restarts after ch3.
3. Backpressure: one pending word, up_ready=0 for 5 cycles -> data_valid=1 and up_data unchanged throughout; up_ready=1 -> exactly one transfer, then data_valid=0.
4. Overflow: up_ready=0, 17 writes on ch0 (DEPTH=16) -> ch_full[0]=1 after the 16th, 17th dropped, ch_ovf[0]=1. Drain yields seq 0x0000..0x000F. One more write then arrives with seq 0x0011. With the macro defined: drop_cnt[0]=1.
5. Reset mid-stream: assert rst_n=0 while data_valid=1 and FIFOs hold data -> data_valid=0 immediately. After release: no output until new writes, and seq restarts at 0.
6. Wrap: 65537 writes on ch1 with up_ready=1 -> the last two words carry seq 0xFFFF then 0x0000; ch_ovf stays 0.
